// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants plus helpers, shared by the scan, sprite and pixel-select logic.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [CNT_W-1:0] pos_t;

  // True when pos lies in the half-open window [lo, lo+len).
  function automatic logic inWindow(pos_t pos, int lo, int len);
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

endpackage

// File: rtl/pix_strobe_gen.sv
// Pixel-rate divider: pix_en is high for the one clk in which the divider sits at its last phase while running.
module pix_strobe_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  assign pix_en = run && (r_div == DIV_LAST);

  // Phase is simply held while stopped so a resume continues mid-pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (run) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: position counters, sync/active decode and frame strobe, all registered.
// Optional build macro VGA_SCAN_FRAME_CNT_EN adds an 8-bit wrapping frame counter output.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       frame_tick
`ifdef VGA_SCAN_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam pos_t H_LAST  = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST  = pos_t'(V_TOTAL - 1);

  logic w_stb;
  pos_t w_hNext, w_vNext;
  logic w_validNext, w_tickNext;

  pos_t r_hPos, r_vPos;
  logic r_pixEn, r_frameTick, r_hsync, r_vsync, r_valid;
  logic [9:0] r_hCnt, r_vCnt;

  pix_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .pix_en(w_stb)
  );

  always_comb begin
    w_hNext = r_hPos;
    w_vNext = r_vPos;
    if (w_stb) begin
      if (r_hPos == H_LAST) begin
        w_hNext = '0;
        w_vNext = (r_vPos == V_LAST) ? '0 : r_vPos + pos_t'(1);
      end else begin
        w_hNext = r_hPos + pos_t'(1);
      end
    end
  end

  assign w_validNext = (int'(w_hNext) < H_ACTIVE) && (int'(w_vNext) < V_ACTIVE);
  assign w_tickNext  = w_stb && (w_hNext == '0) && (w_vNext == '0);

  // Outputs decode the next position so they line up with the counters on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hPos      <= H_LAST;
      r_vPos      <= V_LAST;
      r_pixEn     <= 1'b0;
      r_frameTick <= 1'b0;
      r_hCnt      <= '0;
      r_vCnt      <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_valid     <= 1'b0;
    end else begin
      r_hPos      <= w_hNext;
      r_vPos      <= w_vNext;
      r_pixEn     <= w_stb;
      r_frameTick <= w_tickNext;
      r_hCnt      <= w_validNext ? w_hNext : '0;
      r_vCnt      <= w_validNext ? w_vNext : '0;
      r_hsync     <= !inWindow(w_hNext, H_ACTIVE + H_FP, H_SYNC);
      r_vsync     <= !inWindow(w_vNext, V_ACTIVE + V_FP, V_SYNC);
      r_valid     <= w_validNext;
    end
  end

  assign pix_en     = r_pixEn;
  assign frame_tick = r_frameTick;
  assign h_cnt      = r_hCnt;
  assign v_cnt      = r_vCnt;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign valid      = r_valid;

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [7:0] r_frameCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCnt <= '0;
    end else if (w_tickNext) begin
      r_frameCnt <= r_frameCnt + 8'd1;
    end
  end

  assign frame_cnt = r_frameCnt;
`else
  // Without the frame counter there is no extra state in this build.
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default-timing instance and a tiny-timing instance checked against a frame-index model.
module tb_vga_scan_gen;

  localparam int D_CD = 4, D_HA = 640, D_HF = 16, D_HS = 96, D_HT = 800;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2, D_VT = 525;
  localparam int S_CD = 3, S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1, S_HT = 8;
  localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1, S_VT = 6;

  typedef struct packed {
    logic       pixEn;
    logic       frameTick;
    logic [9:0] hCnt;
    logic [9:0] vCnt;
    logic       hsync;
    logic       vsync;
    logic       valid;
  } obs_t;

  typedef struct packed {
    int div;
    int idx;
    bit pe;
    bit ft;
    int fc;
  } mstate_t;

  typedef struct {
    int   idx;
    logic valid;
    logic hsync;
    int   hCnt;
    int   vCnt;
  } vec_t;

  logic clk, rst_n, run;
  logic dPixEn, dHsync, dVsync, dValid, dFrameTick;
  logic sPixEn, sHsync, sVsync, sValid, sFrameTick;
  logic [9:0] dHcnt, dVcnt, sHcnt, sVcnt;
`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [7:0] dFrameCnt, sFrameCnt;
`endif

  int compared = 0;
  int mismatched = 0;
  int hsLow = 0;
  bit chkOn = 0;
  mstate_t mD, mS;
  obs_t dObs, sObs;
  vec_t tbl[10];

  assign dObs = {dPixEn, dFrameTick, dHcnt, dVcnt, dHsync, dVsync, dValid};
  assign sObs = {sPixEn, sFrameTick, sHcnt, sVcnt, sHsync, sVsync, sValid};

  vga_scan_gen u_def (
    .clk(clk), .rst_n(rst_n), .run(run), .pix_en(dPixEn), .h_cnt(dHcnt), .v_cnt(dVcnt),
    .hsync(dHsync), .vsync(dVsync), .valid(dValid), .frame_tick(dFrameTick)
`ifdef VGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(dFrameCnt)
`endif
  );

  vga_scan_gen #(
    .CLK_DIV(S_CD), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .run(run), .pix_en(sPixEn), .h_cnt(sHcnt), .v_cnt(sVcnt),
    .hsync(sHsync), .vsync(sVsync), .valid(sValid), .frame_tick(sFrameTick)
`ifdef VGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(sFrameCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mkObs(logic pe, logic ft, int h, int v, logic hs, logic vs, logic val);
    obs_t o;
    o.pixEn = pe; o.frameTick = ft; o.hCnt = 10'(h); o.vCnt = 10'(v);
    o.hsync = hs; o.vsync = vs; o.valid = val;
    return o;
  endfunction

  function automatic mstate_t rstState(int tot);
    mstate_t s;
    s.div = 0; s.idx = tot - 1; s.pe = 0; s.ft = 0; s.fc = 0;
    return s;
  endfunction

  // The model tracks a linear pixel index within the frame; row/column come from division.
  function automatic mstate_t stepModel(mstate_t s, logic runIn, int cd, int tot);
    mstate_t n;
    n = s; n.pe = 0; n.ft = 0;
    if (runIn) begin
      if (s.div == cd - 1) begin
        n.div = 0;
        n.idx = (s.idx + 1) % tot;
        n.pe  = 1;
        n.ft  = (n.idx == 0);
        if (n.ft) n.fc = (s.fc + 1) % 256;
      end else begin
        n.div = s.div + 1;
      end
    end
    return n;
  endfunction

  function automatic obs_t expObs(mstate_t m, int ha, int hf, int hs, int ht, int va, int vf, int vs);
    int h, v;
    logic val;
    h = m.idx % ht;
    v = m.idx / ht;
    val = (h < ha) && (v < va);
    return mkObs(m.pe, m.ft, val ? h : 0, val ? v : 0,
                 !(h >= ha + hf && h < ha + hf + hs), !(v >= va + vf && v < va + vf + vs), val);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mD <= rstState(D_HT * D_VT);
      mS <= rstState(S_HT * S_VT);
    end else begin
      mD <= stepModel(mD, run, D_CD, D_HT * D_VT);
      mS <= stepModel(mS, run, S_CD, S_HT * S_VT);
    end
  end

  task automatic checkOutput(input string name, input obs_t got, input obs_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got pe=%0b ft=%0b h=%0d v=%0d hs=%0b vs=%0b val=%0b, want pe=%0b ft=%0b h=%0d v=%0d hs=%0b vs=%0b val=%0b",
               name, got.pixEn, got.frameTick, got.hCnt, got.vCnt, got.hsync, got.vsync, got.valid,
               want.pixEn, want.frameTick, want.hCnt, want.vCnt, want.hsync, want.vsync, want.valid);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic rstnV, input logic runV);
    @(negedge clk);
    rst_n = rstnV;
    run   = runV;
  endtask

  // Waits for the advance cycle that lands on a given frame index of either instance.
  task automatic waitIdx(input bit useSmall, input int target, output bit ok);
    ok = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (!useSmall && dPixEn && !dHsync && mD.idx < D_HT) hsLow++;
      if (useSmall ? (mS.idx == target && mS.pe) : (mD.idx == target && mD.pe)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkInt($sformatf("waitIdx%0d_reached", target), 0, 1);
  endtask

  always @(negedge clk) begin
    if (chkOn) begin
      checkOutput("cycleDef", dObs, expObs(mD, D_HA, D_HF, D_HS, D_HT, D_VA, D_VF, D_VS));
      checkOutput("cycleSmall", sObs, expObs(mS, S_HA, S_HF, S_HS, S_HT, S_VA, S_VF, S_VS));
`ifdef VGA_SCAN_FRAME_CNT_EN
      checkInt("frameCntDef", int'(dFrameCnt), mD.fc);
      checkInt("frameCntSmall", int'(sFrameCnt), mS.fc);
`endif
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    obs_t rstObs, firstObs;
    bit ok;
    int dEdge, sEdge, gap, clks, pix, vsLowPix, firstVs, sTicks;

    tbl[0] = '{1,   1'b1, 1'b1, 1,   0};
    tbl[1] = '{639, 1'b1, 1'b1, 639, 0};
    tbl[2] = '{640, 1'b0, 1'b1, 0,   0};
    tbl[3] = '{655, 1'b0, 1'b1, 0,   0};
    tbl[4] = '{656, 1'b0, 1'b0, 0,   0};
    tbl[5] = '{751, 1'b0, 1'b0, 0,   0};
    tbl[6] = '{752, 1'b0, 1'b1, 0,   0};
    tbl[7] = '{799, 1'b0, 1'b1, 0,   0};
    tbl[8] = '{800, 1'b1, 1'b1, 0,   1};
    tbl[9] = '{801, 1'b1, 1'b1, 1,   1};
    rstObs   = mkObs(0, 0, 0, 0, 1, 1, 0);
    firstObs = mkObs(1, 1, 0, 0, 1, 1, 1);

    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetDef", dObs, rstObs);
    checkOutput("resetSmall", sObs, rstObs);
    chkOn = 1;

    $display("[TB] release reset, first pixel");
    applyStimulus(1'b1, 1'b1);
    dEdge = 0;
    sEdge = 0;
    for (int n = 1; n <= 20 && (dEdge == 0 || sEdge == 0); n++) begin
      @(negedge clk);
      if (dPixEn && dEdge == 0) begin
        dEdge = n;
        checkOutput("firstPixDef", dObs, firstObs);
      end
      if (sPixEn && sEdge == 0) begin
        sEdge = n;
        checkOutput("firstPixSmall", sObs, firstObs);
      end
    end
    checkInt("firstPixEdgeDef", dEdge, D_CD);
    checkInt("firstPixEdgeSmall", sEdge, S_CD);

    $display("[TB] line 0 column table");
    for (int i = 0; i < 10; i++) begin
      waitIdx(1'b0, tbl[i].idx, ok);
      if (ok)
        checkOutput($sformatf("table_idx%0d", tbl[i].idx), dObs,
                    mkObs(1, 0, tbl[i].hCnt, tbl[i].vCnt, tbl[i].hsync, 1, tbl[i].valid));
    end
    checkInt("hsyncLowPixels", hsLow, 96);

    gap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (dPixEn) begin
        gap = n;
        break;
      end
    end
    checkInt("pixEnPeriod", gap, D_CD);

    $display("[TB] pause at column 100");
    waitIdx(1'b0, D_HT + 100, ok);
    @(negedge clk);
    checkOutput("pauseEntry", dObs, mkObs(0, 0, 100, 1, 1, 1, 1));
    run = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("pauseHold", dObs, mkObs(0, 0, 100, 1, 1, 1, 1));
    end
    run = 1'b1;
    gap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (dPixEn) begin
        gap = n;
        break;
      end
    end
    checkInt("resumePhase", gap, D_CD - 1);
    checkOutput("resumePixel", dObs, mkObs(1, 0, 101, 1, 1, 1, 1));

    $display("[TB] random run toggling");
    for (int i = 0; i < 2000; i++) applyStimulus(1'b1, ($urandom_range(0, 3) != 0));
    applyStimulus(1'b1, 1'b1);

    $display("[TB] asynchronous reset mid-frame");
    waitIdx(1'b1, 2 * S_HT + 1, ok);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstDef", dObs, rstObs);
    checkOutput("asyncRstSmall", sObs, rstObs);
`ifdef VGA_SCAN_FRAME_CNT_EN
    checkInt("asyncRstFrameCnt", int'(sFrameCnt), 0);
`endif
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    sEdge = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sPixEn) begin
        sEdge = n;
        checkOutput("restartPixSmall", sObs, firstObs);
        break;
      end
    end
    checkInt("restartEdgeSmall", sEdge, S_CD);

    $display("[TB] full frame on small timing");
    clks = 0;
    pix = 0;
    vsLowPix = 0;
    firstVs = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      clks++;
      if (sPixEn) begin
        pix++;
        if (!sVsync) begin
          vsLowPix++;
          if (firstVs < 0) firstVs = pix;
        end
      end
      if (sFrameTick) break;
    end
    checkInt("frameClks", clks, 144);
    checkInt("framePixEn", pix, 48);
    checkInt("vsyncLowPixEn", vsLowPix, 8);
    checkInt("vsyncStartPix", firstVs, 32);

`ifdef VGA_SCAN_FRAME_CNT_EN
    $display("[TB] frame counter wrap");
    sTicks = 2;
    for (int n = 0; n < 40000 && sTicks < 257; n++) begin
      @(negedge clk);
      if (sFrameTick) sTicks++;
    end
    checkInt("frameTicksSeen", sTicks, 257);
    checkInt("frameCntWrap", int'(sFrameCnt), 1);
`else
    sTicks = 0;
`endif

    chkOn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate).
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels (H_TOTAL=800).
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines (V_TOTAL=525).
REQ-004 SHALL have port clk, input, 1: single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port run, input, 1: when 0, divider and counters hold.
REQ-007 SHALL have port pix_en, output, 1: one-clk strobe at each pixel advance.
REQ-008 SHALL have port h_cnt, output, 10: active column 0..H_ACTIVE-1, 0 outside active.
REQ-009 SHALL have port v_cnt, output, 10: active line 0..V_ACTIVE-1, 0 outside active.
REQ-010 SHALL have port hsync, output, 1: horizontal sync, active-low.
REQ-011 SHALL have port vsync, output, 1: vertical sync, active-low.
REQ-012 SHALL have port valid, output, 1: high only in active area.
REQ-013 SHALL have port frame_tick, output, 1: one-clk pulse at frame start.

Function
REQ-014 SHALL count pix_div 0..CLK_DIV-1 while run=1; pix_en=1 for exactly the clk cycle in which pix_div==CLK_DIV-1 and run=1.
REQ-015 SHALL increment h_pos (0..H_TOTAL-1) on each pix_en; at H_TOTAL-1 it wraps to 0 and v_pos increments.
REQ-016 SHALL wrap v_pos from V_TOTAL-1 to 0 when h_pos wraps on line V_TOTAL-1.
REQ-017 SHALL register all outputs from the next-state counters, so outputs are coherent with h_pos/v_pos on the same edge (zero added latency vs. counters).
REQ-018 SHALL drive hsync=0 iff H_ACTIVE+H_FP <= h_pos < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-019 SHALL drive vsync=0 iff V_ACTIVE+V_FP <= v_pos < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-020 SHALL drive valid=1 iff h_pos<H_ACTIVE and v_pos<V_ACTIVE; h_cnt=h_pos, v_cnt=v_pos when valid, else 0.
REQ-021 SHALL pulse frame_tick for one clk on the edge where position becomes (0,0).
REQ-022 SHALL, when run=0, freeze pix_div, counters and level outputs, and hold pix_en and frame_tick at 0; resuming continues from the frozen pix_div.

Reset
REQ-023 SHALL, while rst_n=0, force pix_div=0, h_pos=H_TOTAL-1, v_pos=V_TOTAL-1, h_cnt=0, v_cnt=0, hsync=1, vsync=1, valid=0, pix_en=0, frame_tick=0.
REQ-024 SHALL, after rst_n rises with run=1, produce the first pix_en and frame_tick on the CLK_DIV-th rising edge, landing at (0,0) with valid=1.
REQ-025 SHALL, on rst_n assertion mid-frame, return immediately to the REQ-023 values with no partial line completed.

Configuration
REQ-026 SHALL, with VGA_SCAN_FRAME_CNT_EN defined, add output frame_cnt[7:0], reset 0, incremented on each frame_tick, wrapping 255->0.
REQ-027 SHALL, without VGA_SCAN_FRAME_CNT_EN, omit port frame_cnt and its register; all other behaviour is identical.

Structure
REQ-028 SHALL place default timing constants and H_TOTAL/V_TOTAL derivations in shared package vga_timing_pkg, for reuse by sprite and pixel-select logic.
REQ-029 SHALL implement the divider as sub-module pix_strobe_gen (inputs clk, rst_n, run; output pix_en); counters and decode stay in vga_scan_gen.

Verification
REQ-030 SHALL cover: release rst_n, run=1 -> pix_en every 4 clks; first at edge 4 with frame_tick=1, h_cnt=0, v_cnt=0, valid=1.
REQ-031 SHALL cover: advance to h_pos=639->640 -> valid falls to 0, h_cnt=0; hsync=0 exactly for h_pos 656..751 (96 pixels).
REQ-032 SHALL cover: a full frame -> 420000 pix_en between frame_ticks (1680000 clks); vsync low for 2 lines (1600 pix_en) starting at v_pos=490.
REQ-033 SHALL cover: run=0 for 10 clks at h_pos=100 -> outputs frozen, no pix_en; after resume the next pix_en arrives at the same pix_div phase.
REQ-034 SHALL cover: rst_n asserted at v_pos=300 -> outputs equal REQ-023 values within the same cycle, with no clock edge required.
REQ-035 SHALL cover, with VGA_SCAN_FRAME_CNT_EN defined: 257 frames -> frame_cnt=1 after wrapping through 255->0.
